instr_loader: RTL

- Accepts decoded instruction descriptors (kind plus register/immediate fields) over a valid/ready stream and encodes each into a 32-bit MIPS instruction word.
- Writes the encoded words sequentially into instruction memory through a synchronous write port.
- Is the encoding counterpart of the op/funct control decoder and uses the same opcode/funct values.
- Sits outside the core: drives imem during program load, before the core is released from reset.

---
 rtl/instr_loader_pkg.sv | 55 +++++
 rtl/instr_loader_encode.sv | 39 +++
 rtl/instr_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared MIPS encoding constants for the program loader.
// Holds the primary opcodes, the R-type funct codes, the descriptor kind
// enumeration and the loader FSM states. The op/funct control decoder imports
// the same constants, so encoder and decoder cannot drift apart.
package instr_loader_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Descriptor kinds; codes 10..15 are illegal
  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_ADDI = 4'd5,
    KIND_LB   = 4'd6,
    KIND_SB   = 4'd7,
    KIND_BEQ  = 4'd8,
    KIND_J    = 4'd9
  } kind_e;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // R-type word: shamt is always zero for the supported kinds
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  // I-type word
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_loader_encode.sv
// instr_encode: purely combinational descriptor encoder.
// Ports: kind/rs/rt/rd/imm/target in -> 32-bit MIPS word plus legal flag.
// Fields that a kind does not use are ignored; illegal kinds give word 0.
module instr_encode
  import instr_loader_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // Map each kind to its instruction format and op/funct
  always_comb begin
    word  = 32'd0;
    legal = 1'b1;
    case (kind)
      KIND_ADD:  word = enc_r(rs, rt, rd, FUNCT_ADD);
      KIND_SUB:  word = enc_r(rs, rt, rd, FUNCT_SUB);
      KIND_AND:  word = enc_r(rs, rt, rd, FUNCT_AND);
      KIND_OR:   word = enc_r(rs, rt, rd, FUNCT_OR);
      KIND_SLT:  word = enc_r(rs, rt, rd, FUNCT_SLT);
      KIND_ADDI: word = enc_i(OP_ADDI, rs, rt, imm);
      KIND_LB:   word = enc_i(OP_LB, rs, rt, imm);
      KIND_SB:   word = enc_i(OP_SB, rs, rt, imm);
      KIND_BEQ:  word = enc_i(OP_BEQ, rs, rt, imm);
      KIND_J:    word = {OP_J, target};
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams decoded instruction descriptors into imem.
// Inputs : clk, reset_n (async, active-low), start, in_valid + descriptor
//          fields (in_kind, in_rs/rt/rd, in_imm, in_target, in_last).
// Outputs: in_ready, imem_we/imem_addr/imem_wdata (one-cycle registered write
//          per legal accept), busy, done, err_kind, err_full, count.
// The write pointer is the low part of count: both advance only on legal
// accepts, so a separate pointer register would always equal it.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err_kind,
  output logic                  err_full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_kind_q, err_kind_d;
  logic                  err_full_q, err_full_d;
  logic                  in_ready_q, in_ready_d;
  logic                  done_q, done_d;
  logic [31:0]           enc_word;
  logic                  enc_legal;
  logic                  accept;
  logic [ADDR_WIDTH:0]   count_inc;

  instr_encode u_encode (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // Next-state, pointer, error and write-port computation
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_kind_d = err_kind_q;
    err_full_d = err_full_q;
    accept     = in_valid && (state_q == ST_LOAD);
    count_inc  = count_q + ONE_C;

    // start wins over a same-cycle accept, which is dropped
    if (start) begin
      state_d    = ST_LOAD;
      count_d    = '0;
      err_kind_d = 1'b0;
      err_full_d = 1'b0;
    end else if (accept) begin
      if (enc_legal) begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_WIDTH-1:0];
        wdata_d = enc_word;
        count_d = count_inc;
        if (in_last) begin
          state_d = ST_DONE;
        end else if (count_inc == DEPTH_C) begin
          state_d    = ST_DONE;
          err_full_d = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end else begin
        err_kind_d = 1'b1;
        if (in_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
    end else begin
      state_d = state_q;
    end

    in_ready_d = (state_d == ST_LOAD);
    done_d     = (state_d == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      err_kind_q <= 1'b0;
      err_full_q <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_kind_q <= err_kind_d;
      err_full_q <= err_full_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = in_ready_q;
  assign done       = done_q;
  assign err_kind   = err_kind_q;
  assign err_full   = err_full_q;
  assign count      = count_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule
